// File: rtl/ifetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// No logic here; latency and backpressure belong to the modules that import it.
package ifetch_buffer_pkg;

    localparam int          FE_AWIDTH         = 32;
    localparam int          FE_DWIDTH         = 32;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;
    localparam logic [31:0] NOP_INSN          = 32'h0000_0013;

    typedef struct packed {
        logic [FE_AWIDTH-1:0] pc;
        logic [FE_DWIDTH-1:0] insn;
    } fetch_entry_t;

    // Byte address of the word containing addr.
    function automatic logic [FE_AWIDTH-1:0] word_align(input logic [FE_AWIDTH-1:0] addr);
        return {addr[FE_AWIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_buffer_fifo.sv
// First-word-fall-through queue of fetch entries with push, pop, flush and occupancy count.
// Latency: a push is visible at the head the next cycle; backpressure: pops only while non-empty, flush wins over push/pop.
module fetch_fifo
    import ifetch_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push_vld,
    input  fetch_entry_t  i_push_dat,
    input  logic          i_pop_rdy,
    output logic          o_head_vld,
    output fetch_entry_t  o_head_dat,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full     = (r_count == CW'(DEPTH));
    assign o_head_vld = (r_count != '0);
    assign w_do_pop   = i_pop_rdy && o_head_vld && !i_flush;
    assign w_do_push  = i_push_vld && !w_full && !i_flush;
    assign o_count    = r_count;
    assign o_head_dat = o_head_vld ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // The fetch side reserves a slot before issuing, so a push must never find the queue full.
    assert property (@(posedge clk) disable iff (!rst) !(i_push_vld && w_full && !i_flush));

endmodule

// File: rtl/ifetch_buffer.sv
// Sequential PC generator and 1-cycle-latency imem read issue feeding a FWFT {pc, insn} queue toward decode.
// Latency: 2 cycles reset/redirect to first valid; backpressure: reads stop once queued + in-flight fill DEPTH.
module ifetch_buffer
    import ifetch_buffer_pkg::*;
#(
    parameter int              AWIDTH    = FE_AWIDTH,
    parameter int              DWIDTH    = FE_DWIDTH,
    parameter int              DEPTH     = 4,
    parameter logic [AWIDTH-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_o,
    output logic [AWIDTH-1:0]        imem_addr_o,
    input  logic [DWIDTH-1:0]        imem_data_i,
    input  logic                     redirect_i,
    input  logic [AWIDTH-1:0]        redirect_pc_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [AWIDTH-1:0]        pc_o,
    output logic [DWIDTH-1:0]        insn_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [AWIDTH-1:0] r_fetch_pc;
    logic [AWIDTH-1:0] r_req_pc;
    logic              r_inflight;

    logic [CW-1:0]     w_count;
    logic [OW-1:0]     w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_push_dat;
    fetch_entry_t      w_head_dat;

    // An outstanding read already owns a queue slot, so it counts toward occupancy.
    assign w_occupancy = OW'(w_count) + OW'(r_inflight);
    assign w_issue     = rst && !redirect_i && (w_occupancy < OW'(DEPTH));

    assign imem_req_o  = w_issue;
    assign imem_addr_o = r_fetch_pc;

    // Redirect flushes the queue and drops the response that lands in the same cycle.
    assign w_push      = r_inflight && !redirect_i;
    assign w_pop       = valid_o && ready_i;

    always_comb begin
        w_push_dat      = '0;
        w_push_dat.pc   = r_req_pc;
        w_push_dat.insn = imem_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= BASE_ADDR;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_i) begin
            r_fetch_pc <= word_align(redirect_pc_i);
            r_inflight <= 1'b0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + AWIDTH'(4);
                r_req_pc   <= r_fetch_pc;
            end
            r_inflight <= w_issue;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (redirect_i),
        .i_push_vld (w_push),
        .i_push_dat (w_push_dat),
        .i_pop_rdy  (w_pop),
        .o_head_vld (valid_o),
        .o_head_dat (w_head_dat),
        .o_count    (w_count)
    );

    assign count_o = w_count;
    assign pc_o    = w_head_dat.pc;
    assign insn_o  = w_head_dat.insn;

endmodule
